// File: rtl/hamming_dec_stream_pkg.sv
// hamming_dec_stream_pkg
//   Shared Hamming(12,8) definitions: code/data/parity widths, the
//   data-bit -> Hamming-position map and the syndrome function.
//   Optional macro HAMMING_SECDED_EN widens the codeword by one overall
//   even-parity bit (bit 12).
package hamming_dec_stream_pkg;

    localparam int HAMMING_OUT_8 = 8;
    localparam int HAMMING_PAR_8 = 4;
`ifdef HAMMING_SECDED_EN
    localparam int HAMMING_IN_8  = 13;
`else
    localparam int HAMMING_IN_8  = 12;
`endif

    // Hamming position of data bit i (d0..d7 -> 3,5,6,7,9,10,11,12).
    function automatic logic [3:0] data_pos(input int i);
        logic [3:0] p;
        case (i)
            0:       p = 4'd3;
            1:       p = 4'd5;
            2:       p = 4'd6;
            3:       p = 4'd7;
            4:       p = 4'd9;
            5:       p = 4'd10;
            6:       p = 4'd11;
            7:       p = 4'd12;
            default: p = 4'd0;
        endcase
        return p;
    endfunction

    // Syndrome = XOR of the positions of all set bits. Parity bit p(2^k)
    // sits at position 2^k, so the received parity nibble folds in as-is.
    function automatic logic [3:0] hamming_syn8(input logic [11:0] code);
        logic [3:0] s;
        s = code[3:0];
        for (int i = 0; i < 8; i++)
            if (code[4+i]) s ^= data_pos(i);
        return s;
    endfunction

endpackage

// File: rtl/hamming_dec_stream_syndrome.sv
// hamming_syndrome_8
//   Combinational syndrome and correction decode for one codeword.
//   Ports:
//     code      - received codeword (12 bits, 13 with HAMMING_SECDED_EN)
//     syn       - 4-bit syndrome
//     corr_mask - data bits to flip
//     corr      - a single error was corrected (data or parity bit)
//     uncorr    - uncorrectable error detected
module hamming_syndrome_8
    import hamming_dec_stream_pkg::*;
(
    input  logic [HAMMING_IN_8-1:0]  code,
    output logic [HAMMING_PAR_8-1:0] syn,
    output logic [HAMMING_OUT_8-1:0] corr_mask,
    output logic                     corr,
    output logic                     uncorr
);

    always_comb begin
        syn       = hamming_syn8(code[11:0]);
        corr_mask = '0;
        corr      = 1'b0;
        uncorr    = 1'b0;
        // Syndromes 1..12 all name a real position (parity or data);
        // 13..15 point past the codeword.
        if (syn > 4'd12) begin
            uncorr = 1'b1;
        end else if (syn != 4'd0) begin
            corr = 1'b1;
            for (int i = 0; i < HAMMING_OUT_8; i++)
                corr_mask[i] = (syn == data_pos(i));
        end
`ifdef HAMMING_SECDED_EN
        // Overall parity intact but syndrome non-zero: two bits flipped.
        if (!(^code) && syn != 4'd0) begin
            corr      = 1'b0;
            uncorr    = 1'b1;
            corr_mask = '0;
        end else if ((^code) && syn == 4'd0) begin
            // Only the overall parity bit itself is wrong.
            corr = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/hamming_dec_stream.sv
// hamming_dec_stream
//   Two-stage streaming Hamming(12,8) SEC decoder with valid/ready on both
//   sides and saturating corrected/uncorrectable word counters.
//   S1 holds the received code; S2 holds corrected data and flags, which
//   drive the outputs directly.
//   Optional macro HAMMING_SECDED_EN: 13-bit code with overall parity for
//   double-error detection.
//   Ports:
//     sys_clk, rst        - clock, synchronous active-high reset
//     in_valid/in_ready   - input handshake, in_code codeword
//     out_valid/out_ready - output handshake
//     out_data/out_corr/out_uncorr/out_syn - decoded result
//     stat_clr            - clears both counters (wins over increment)
//     corr_cnt/uncorr_cnt - saturating statistics
module hamming_dec_stream
    import hamming_dec_stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PAR_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [HAMMING_IN_8-1:0] in_code,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_corr,
    output logic                    out_uncorr,
    output logic [PAR_W-1:0]        out_syn,
    input  logic                    stat_clr,
    output logic [CNT_W-1:0]        corr_cnt,
    output logic [CNT_W-1:0]        uncorr_cnt
);

    localparam int STAGES = 2;

    logic [STAGES:1]         vld_pipe;
    logic [HAMMING_IN_8-1:0] s1_code;
    logic [PAR_W-1:0]        dec_syn;
    logic [DATA_W-1:0]       dec_mask;
    logic                    dec_corr;
    logic                    dec_uncorr;
    logic                    s1_adv;
    logic                    s2_adv;
    logic                    out_hs;

    hamming_syndrome_8 u_syn (
        .code      (s1_code),
        .syn       (dec_syn),
        .corr_mask (dec_mask),
        .corr      (dec_corr),
        .uncorr    (dec_uncorr)
    );

    // A stage may load when it is empty or its contents leave this cycle.
    assign s2_adv    = !vld_pipe[2] || out_ready;
    assign s1_adv    = !vld_pipe[1] || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = vld_pipe[2];
    assign out_hs    = vld_pipe[2] && out_ready;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            vld_pipe   <= '0;
            s1_code    <= '0;
            out_data   <= '0;
            out_corr   <= 1'b0;
            out_uncorr <= 1'b0;
            out_syn    <= '0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) s1_code <= in_code;
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    out_data   <= s1_code[11:4] ^ dec_mask;
                    out_corr   <= dec_corr;
                    out_uncorr <= dec_uncorr;
                    out_syn    <= dec_syn;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst || stat_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_hs) begin
            if (out_corr && corr_cnt != '1)
                corr_cnt <= corr_cnt + CNT_W'(1);
            if (out_uncorr && uncorr_cnt != '1)
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_dec_stream.sv
// tb_hamming_dec_stream
//   Randomized + directed bench with a queue scoreboard. The reference
//   model decodes by XOR-ing the position numbers of all set bits.
module tb_hamming_dec_stream;

`ifdef HAMMING_SECDED_EN
    localparam int CW = 13;
`else
    localparam int CW = 12;
`endif
    localparam int CNT_W = 2;
    localparam int MAXC  = 3;

    typedef struct packed {
        logic [7:0] data;
        logic       corr;
        logic       uncorr;
        logic [3:0] syn;
    } exp_t;

    logic             sys_clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [CW-1:0]    in_code = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       out_data;
    logic             out_corr;
    logic             out_uncorr;
    logic [3:0]       out_syn;
    logic             stat_clr = 1'b0;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    hamming_dec_stream #(.DATA_W(8), .PAR_W(4), .CNT_W(CNT_W)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_corr   (out_corr),
        .out_uncorr (out_uncorr),
        .out_syn    (out_syn),
        .stat_clr   (stat_clr),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];
    int   dpos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, want);
    endtask

    function automatic logic [CW-1:0] encode(input logic [7:0] d);
        logic [CW-1:0] c;
        int s;
        c = '0;
        c[11:4] = d;
        s = 0;
        for (int i = 0; i < 8; i++) if (d[i]) s ^= dpos[i];
        // parity bit at position 2^k cancels syndrome bit k
        for (int k = 0; k < 4; k++) c[k] = s[k];
`ifdef HAMMING_SECDED_EN
        c[12] = ^c[11:0];
`endif
        return c;
    endfunction

    function automatic exp_t model(input logic [CW-1:0] c);
        exp_t e;
        int s;
        logic [7:0] d;
        s = 0;
        for (int k = 0; k < 4; k++) if (c[k]) s ^= (1 << k);
        for (int i = 0; i < 8; i++) if (c[4+i]) s ^= dpos[i];
        d = c[11:4];
        e.corr = 1'b0;
        e.uncorr = 1'b0;
        if (s > 12) e.uncorr = 1'b1;
        else if (s != 0) begin
            e.corr = 1'b1;
            for (int i = 0; i < 8; i++) if (dpos[i] == s) d[i] = ~d[i];
        end
`ifdef HAMMING_SECDED_EN
        if (!(^c) && s != 0) begin
            e.corr = 1'b0;
            e.uncorr = 1'b1;
            d = c[11:4];
        end else if ((^c) && s == 0) e.corr = 1'b1;
`endif
        e.data = d;
        e.syn = s[3:0];
        return e;
    endfunction

    // One cycle: drive inputs just after posedge, report accept at negedge.
    task automatic cyc(input logic v, input logic [CW-1:0] c, input logic ordy,
                       input logic clr, output logic acc);
        @(posedge sys_clk); #1;
        in_valid = v; in_code = c; out_ready = ordy; stat_clr = clr;
        @(negedge sys_clk);
        acc = v && in_ready && !rst;
        if (acc) exp_q.push_back(model(c));
    endtask

    task automatic send(input logic [CW-1:0] c);
        logic acc;
        int tries;
        tries = 0;
        do begin
            cyc(1'b1, c, 1'b1, 1'b0, acc);
            tries++;
        end while (!acc && tries < 20);
        if (!acc) check("send timeout", 0, 1);
    endtask

    task automatic dir_chk(input string nm, input logic [11:0] c12, input logic p12,
                           input logic [7:0] xd, input logic [3:0] xs,
                           input logic xc, input logic xu);
        logic [CW-1:0] c;
        logic acc;
        int lat;
        c = CW'({p12, c12});
        send(c);
        lat = 0;
        do begin
            cyc(1'b0, '0, 1'b1, 1'b0, acc);
            lat++;
        end while (!out_valid && lat < 8);
        check({nm, " latency"}, lat, 2);
        check({nm, " result"}, {out_data, out_corr, out_uncorr, out_syn}, {xd, xc, xu, xs});
    endtask

    // Scoreboard monitor and counter model.
    exp_t held;
    bit   hold_v = 1'b0;
    int   m_corr = 0;
    int   m_uncorr = 0;
    always @(negedge sys_clk) begin
        exp_t e;
        exp_t cur;
        bit hc, hu;
        if (mon_en) begin
            hc = 0; hu = 0;
            cur = {out_data, out_corr, out_uncorr, out_syn};
            check("corr_cnt", corr_cnt, m_corr);
            check("uncorr_cnt", uncorr_cnt, m_uncorr);
            if (rst) begin
                exp_q.delete();
                m_corr = 0; m_uncorr = 0; hold_v = 0;
            end else begin
                if (hold_v) begin
                    check("stall valid", out_valid, 1);
                    check("stall stable", cur, held);
                end
                hold_v = out_valid && !out_ready;
                held = cur;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check("unexpected output", cur, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("output word", cur, e);
                        hc = e.corr; hu = e.uncorr;
                    end
                end
                if (stat_clr) begin
                    m_corr = 0; m_uncorr = 0;
                end else begin
                    if (hc && m_corr < MAXC) m_corr++;
                    if (hu && m_uncorr < MAXC) m_uncorr++;
                end
            end
        end
    end

    initial begin
        logic acc;
        logic [CW-1:0] rc, err1;
        logic pend;
        int nerr, b1, b2;
        logic v;

        repeat (1) @(posedge sys_clk);
        #1 mon_en = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 rst = 1'b0;
        @(negedge sys_clk);
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 1);
        check("reset outputs", {out_data, out_corr, out_uncorr, out_syn}, 0);

        // Directed vectors; bit 12 (SECDED only) is the clean word's parity.
        dir_chk("clean",  12'h0A2, 1'b1, 8'h0A, 4'd0,  1'b0, 1'b0);
        dir_chk("d1 err", 12'h082, 1'b1, 8'h0A, 4'd5,  1'b1, 1'b0);
        dir_chk("p4 err", 12'hFF7, 1'b0, 8'hFF, 4'd4,  1'b1, 1'b0);
        dir_chk("double", 12'h8B2, 1'b1, 8'h8B, 4'd15, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0, acc);
        check("dir corr_cnt", corr_cnt, 2);
        check("dir uncorr_cnt", uncorr_cnt, 1);

        // Backpressure: pipe fills after two words.
        cyc(1'b1, encode(8'h0A), 1'b0, 1'b0, acc);
        check("bp accept1", acc, 1);
        cyc(1'b1, encode(8'hFF), 1'b0, 1'b0, acc);
        check("bp accept2", acc, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, encode(8'h0A), 1'b0, 1'b0, acc);
            check("bp in_ready low", in_ready, 0);
        end
        for (int i = 0; i < 10 && !acc; i++) cyc(1'b1, encode(8'h0A), 1'b1, 1'b0, acc);
        check("bp accept3", acc, 1);
        repeat (4) cyc(1'b0, '0, 1'b1, 1'b0, acc);
        check("bp drained", exp_q.size(), 0);

        // Reset while stalled with a full pipe.
        cyc(1'b1, encode(8'h5A) ^ CW'(1), 1'b0, 1'b0, acc);
        cyc(1'b1, encode(8'h33), 1'b0, 1'b0, acc);
        cyc(1'b0, '0, 1'b0, 1'b0, acc);
        @(posedge sys_clk); #1 rst = 1'b1;
        @(negedge sys_clk);
        @(posedge sys_clk); #1 rst = 1'b0;
        @(negedge sys_clk);
        check("mid rst out_valid", out_valid, 0);
        check("mid rst in_ready", in_ready, 1);
        check("mid rst counters", {corr_cnt, uncorr_cnt}, 0);

        // Saturation and clear-vs-increment priority.
        err1 = encode(8'h0A) ^ CW'(12'h020);
        for (int i = 0; i < 5; i++) send(err1);
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, acc);
        check("sat corr_cnt", corr_cnt, 3);
        send(err1);
        cyc(1'b0, '0, 1'b1, 1'b0, acc);
        cyc(1'b0, '0, 1'b1, 1'b1, acc);
        check("clr with output", out_valid, 1);
        cyc(1'b0, '0, 1'b1, 1'b0, acc);
        check("clr priority", corr_cnt, 0);

        // Random traffic with 0/1/2 bit errors and random backpressure.
        pend = 1'b0;
        rc = '0;
        for (int n = 0; n < 800; n++) begin
            if (!pend) begin
                rc = encode(8'($urandom));
                nerr = $urandom % 4;
                if (nerr != 0) begin
                    b1 = $urandom_range(CW - 1, 0);
                    rc[b1] = ~rc[b1];
                    if (nerr == 3) begin
                        b2 = (b1 + 1 + $urandom_range(CW - 2, 0)) % CW;
                        rc[b2] = ~rc[b2];
                    end
                end
            end
            v = pend ? 1'b1 : ($urandom % 4 != 0);
            cyc(v, rc, ($urandom % 4) != 0, ($urandom % 32) == 0, acc);
            pend = v && !acc;
        end
        repeat (10) cyc(1'b0, '0, 1'b1, 1'b0, acc);
        check("final drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hamming_dec_stream.md
Name: hamming_dec_stream

Overview:
- Streaming, pipelined Hamming(12,8) single-error-correcting decoder. It is the receive-side counterpart to the 8-bit Hamming encoder.
- Accepts codewords over a valid/ready handshake and corrects any single-bit error.
- Flags uncorrectable syndromes and keeps saturating error statistics.
- Sits between the channel/storage model and the data consumer in the ECC datapath.

Parameters:
- DATA_W, 8, data bits per codeword; fixed at 8, other values are unsupported.
- PAR_W, 4, Hamming parity bits.
- CNT_W, 16, width of the statistics counters.

Ports:
- sys_clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  codeword present.
- in_ready  out  1  decoder can accept.
- in_code  in  DATA_W+PAR_W (13 with the optional feature)  codeword.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_W  corrected data.
- out_corr  out  1  single error corrected (data or parity bit).
- out_uncorr  out  1  uncorrectable error detected.
- out_syn  out  PAR_W  syndrome of this word.
- stat_clr  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  count of corrected words.
- uncorr_cnt  out  CNT_W  count of uncorrectable words.

Behaviour:
- Codeword layout:
  - in_code[11:4] holds d7..d0; in_code[3:0] holds {p8,p4,p2,p1}.
  - Hamming positions: p1=1, p2=2, p4=4, p8=8.
  - d0..d7 map to positions 3, 5, 6, 7, 9, 10, 11, 12.
- Syndrome: s = recomputed parity XOR received parity, with s[i] for p(2^i). Decode of s:
  - s=0: no error.
  - s in {1,2,4,8}: parity-bit error; data passes unchanged; out_corr=1.
  - s is a data position: flip that data bit; out_corr=1.
  - s in 13..15: out_uncorr=1; data passes raw, uncorrected.
- Pipeline:
  - Two register stages. S1 registers the code and computes the syndrome; S2 registers the corrected data and flags.
  - Latency is 2 cycles from an accepted input to out_valid when there is no backpressure.
  - Throughput is 1 word per cycle.
  - in_ready = !s2_valid | out_ready | !s1_valid. In words: a stage advances when the stage after it is empty or being drained.
  - Each stage holds its contents while stalled.
  - A transfer happens only on valid&ready. Data, flags and syn stay stable while out_valid=1 and out_ready=0.
- Counters:
  - A counter increments on an output handshake carrying the matching flag.
  - Counters saturate at 2^CNT_W-1.
  - stat_clr has priority over an increment in the same cycle; the counter reads 0 on the next cycle.
- Reset:
  - Clears both stage valid bits, out_valid, out_data, out_corr, out_uncorr, out_syn, corr_cnt and uncorr_cnt to 0.
  - in_ready is 1 on the first cycle after reset deasserts.
  - Reset mid-stream drops any words in flight without reporting them.
- Boundary: input and output handshakes in the same cycle under a full pipe must lose no word and duplicate none.

Optional Feature:
- Macro: HAMMING_SECDED_EN.
- Enabled:
  - in_code is 13 bits; bit 12 is overall even parity over bits 11:0.
  - Overall parity checks out and s!=0: double error; out_uncorr=1 and no correction is applied.
  - Overall parity fails and s=0: error in the overall parity bit; out_corr=1.
  - Overall parity fails and s!=0: corrected as in the base decode.
- Disabled: 12-bit input; double errors may miscorrect, which is documented behaviour.

Decomposition:
- Shared package/define file (ecc_define.v) holds:
  - HAMMING_IN_8/OUT_8/PAR_8 widths.
  - The position-to-data-bit map.
  - The syndrome function.
- One natural sub-module: hamming_syndrome_8, the combinational syndrome plus correction mask, reused by the encoder check path.

Test Plan:
- Clean word 0x0A2 -> out_data=0x0A after 2 cycles; corr=0, uncorr=0, syn=0.
- Data error: 0x082 (d1 flipped) -> out_data=0x0A, syn=5, corr=1, corr_cnt=1.
- Parity error: 0xFF7 (p4 flipped) -> out_data=0xFF, syn=4, corr=1.
- Uncorrectable: 0x8B2 (d0 and d7 flipped) -> syn=15, uncorr=1, out_data=0x8B, uncorr_cnt increments.
- Backpressure:
  - Stream 0x0A2, 0xFF3, 0x0A2 with out_ready held low for 4 cycles -> in_ready falls after 2 words.
  - Outputs are then 0x0A, 0xFF, 0x0A in order with no loss.
  - Assert rst mid-stall -> out_valid=0 and counters=0 the next cycle.
- Saturation: with CNT_W=2, send 5 corrected words -> corr_cnt sticks at 3; stat_clr together with a corrected word -> counter reads 0.
